timer_alarm: RTL
================

// Module: timer_alarm
// PURPOSE
//  Memory-mapped consumer of the 64-bit microsecond counter `now` driven by the free-running us timer.
//  Gives the CPU a tear-free 64-bit read of `now` over a 32-bit bus, plus a one-shot/periodic compare alarm raising `irq`.
//  Also issues the clear pulse back to the timer's `we` input.
//  Sits between the CPU data bus (MMIO decode) and the us timer.
// PARAMETERS
//  ADDR_W   4    word-address width of register window
//  SYNC_STG 2    sampling stages on `now` (min 2)
// PORTS
//  CLK100MHZ  in   1   system clock, 100 MHz; the only clock
//  reset      in   1   synchronous, active-high reset
//  now        in   64  us count from timer; changes at most once per 100 clk
//  addr       in   4   word offset within window
//  wr_en      in   1   write strobe, 1 cycle per access
//  wr_data    in   32  write data
//  rd_en      in   1   read strobe, 1 cycle per access
//  rd_data    out  32  read data, valid when rd_valid
//  rd_valid   out  1   1-cycle pulse, exactly 1 clk after rd_en
//  irq        out  1   level interrupt = pending & CTRL.ie
//  clr_now    out  1   1-cycle pulse to timer `we` (clears us count)
// BEHAVIOUR
//  Sampling: `now` comes from a derived-clock register; shift through SYNC_STG regs; now_q <= last stage only
//   when last two stages are equal; otherwise hold. now_q reset 0. Observation latency <= SYNC_STG+1 clk.
//  Register map (word offset): 0 NOW_LO, 1 NOW_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL, 5 STATUS, 6 PERIOD; others read 0, writes ignored.
//   NOW_LO read: returns now_q[31:0] and latches snap_hi <= now_q[63:32] same cycle.
//   NOW_HI read: returns snap_hi (not live). NOW_* writes ignored.
//   CTRL: [0] en, [1] periodic, [2] ie, [3] clr (write-1 -> clr_now pulse next clk; reads 0).
//   STATUS: [0] pending (W1C), [1] armed (RO).
//   PERIOD: 32-bit reload increment, zero-extended to 64.
//  Alarm FSM, states IDLE / HALF / ARMED:
//   IDLE : en=0 or after one-shot fire. Write CMP_LO -> HALF. Write CTRL.en=1 -> ARMED.
//   HALF : CMP_LO written, CMP_HI not yet; no compare. Write CMP_HI -> ARMED if en else IDLE.
//   ARMED: each clk, if now_q >= cmp (64-bit unsigned): pending<=1; periodic ? cmp<=cmp+PERIOD (wrap mod 2^64), stay : -> IDLE.
//          Write CMP_LO -> HALF. Write en=0 -> IDLE.
//   CMP_HI write from IDLE/ARMED -> immediate update, state unchanged.
//  Arming with cmp <= now_q: fires on first ARMED cycle (1 clk after write).
//  Simultaneous W1C of pending and new fire: fire wins, pending stays 1.
//  Periodic with PERIOD=0: fires once, then every clk while now_q >= cmp; legal, software's problem.
//  clr_now: `now` returns to 0; armed compare stays armed, fires again when now_q reaches cmp.
//  Simultaneous rd_en and wr_en: write performed, read returns pre-write value.
//  Reset (any cycle, incl. mid-HALF): state IDLE; cmp=all 1s; PERIOD, CTRL, pending, snap_hi, now_q, sync regs = 0;
//   rd_data=0, rd_valid=0, irq=0, clr_now=0. In-flight read dropped (no rd_valid).
// STRUCTURE
//  Package timer_pkg: register offset localparams, CTRL/STATUS bit indices, alarm_state_t enum {IDLE,HALF,ARMED}.
//  Sub-module timer_now_sync: SYNC_STG sampler + equal-twice capture, outputs now_q.
//  Top holds register file, read mux, alarm FSM, comparator, clr pulse.
// TESTING
//  1 Reset, then read all offsets -> rd_valid 1 clk later; CMP_LO/HI=0xFFFFFFFF, others 0; irq=0.
//  2 now=0x0000_0001_FFFF_FFFF, read NOW_LO, now->0x0000_0002_0000_0000, read NOW_HI -> 0xFFFFFFFF then 0x1 (snapshot).
//  3 CMP=0x0000_0000_0000_0064, CTRL=0x5, now ramps 0..0x70 -> pending/irq rise within SYNC_STG+2 clk of now=0x64; state IDLE.
//  4 periodic: CMP=100, PERIOD=50, CTRL=0x7 -> fires at now=100,150,200; W1C between each clears irq; cmp reads 250.
//  5 write CMP_LO=10 while ARMED with now=500 -> no fire until CMP_HI written; then fires next-but-one clk.
//  6 CTRL write 0x8 -> clr_now high exactly 1 clk; reset asserted mid-HALF -> FSM IDLE, all outputs 0 next clk.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL/STATUS bit positions and alarm states shared by the timer alarm block
package timer_pkg;
  localparam int OFF_NOW_LO = 0;
  localparam int OFF_NOW_HI = 1;
  localparam int OFF_CMP_LO = 2;
  localparam int OFF_CMP_HI = 3;
  localparam int OFF_CTRL   = 4;
  localparam int OFF_STATUS = 5;
  localparam int OFF_PERIOD = 6;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IE  = 2;
  localparam int CTRL_CLR = 3;
  localparam int ST_PEND  = 0;
  localparam int ST_ARMED = 1;
  typedef enum logic [1:0] {IDLE, HALF, ARMED} alarm_state_t;
endpackage

// File: rtl/timer_now_sync.sv
// timer_now_sync: samples the derived-clock us count and only accepts a value seen equal in two stages
module timer_now_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [63:0] now,
  output logic [63:0] now_q
);
  logic [SYNC_STG-1:0][63:0] stg;
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      stg   <= '0;
      now_q <= '0;
    end else begin
      stg <= {stg[SYNC_STG-2:0], now};
      if (stg[SYNC_STG-1] == stg[SYNC_STG-2]) now_q <= stg[SYNC_STG-1];
    end
  end
endmodule

// File: rtl/timer_alarm.sv
// timer_alarm: MMIO window giving tear-free reads of the us count plus a one-shot/periodic compare alarm
module timer_alarm
  import timer_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int SYNC_STG = 2
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic [63:0]       now,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              irq,
  output logic              clr_now
);
  logic [63:0] now_q, cmp;
  logic [31:0] period, snap_hi, rd_mux;
  logic en, periodic, ie, pending;
  logic wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status, wr_period, rd_now_lo, fire;
  alarm_state_t state;

  timer_now_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .now(now),
    .now_q(now_q)
  );

  always_comb begin
    wr_cmp_lo = wr_en && addr == ADDR_W'(OFF_CMP_LO);
    wr_cmp_hi = wr_en && addr == ADDR_W'(OFF_CMP_HI);
    wr_ctrl   = wr_en && addr == ADDR_W'(OFF_CTRL);
    wr_status = wr_en && addr == ADDR_W'(OFF_STATUS);
    wr_period = wr_en && addr == ADDR_W'(OFF_PERIOD);
    rd_now_lo = rd_en && addr == ADDR_W'(OFF_NOW_LO);
    fire      = state == ARMED && now_q >= cmp;
    irq       = pending && ie;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_W'(OFF_NOW_LO): rd_mux = now_q[31:0];
      ADDR_W'(OFF_NOW_HI): rd_mux = snap_hi;
      ADDR_W'(OFF_CMP_LO): rd_mux = cmp[31:0];
      ADDR_W'(OFF_CMP_HI): rd_mux = cmp[63:32];
      ADDR_W'(OFF_CTRL): begin
        rd_mux[CTRL_EN]  = en;
        rd_mux[CTRL_PER] = periodic;
        rd_mux[CTRL_IE]  = ie;
      end
      ADDR_W'(OFF_STATUS): begin
        rd_mux[ST_PEND]  = pending;
        rd_mux[ST_ARMED] = state == ARMED;
      end
      ADDR_W'(OFF_PERIOD): rd_mux = period;
      default: rd_mux = '0;
    endcase
  end

  // Later assignments win: bus writes override the alarm's own updates, and a fire beats W1C.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state    <= IDLE;
      cmp      <= '1;
      period   <= '0;
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      pending  <= 1'b0;
      snap_hi  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      clr_now  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
      clr_now  <= wr_ctrl && wr_data[CTRL_CLR];
      if (rd_now_lo) snap_hi <= now_q[63:32];
      if (wr_status && wr_data[ST_PEND]) pending <= 1'b0;
      if (fire) begin
        pending <= 1'b1;
        if (periodic) cmp <= cmp + {32'd0, period};
        else state <= IDLE;
      end
      if (wr_period) period <= wr_data;
      if (wr_ctrl) begin
        en       <= wr_data[CTRL_EN];
        periodic <= wr_data[CTRL_PER];
        ie       <= wr_data[CTRL_IE];
        if (state == IDLE && wr_data[CTRL_EN]) state <= ARMED;
        if (state == ARMED && !wr_data[CTRL_EN]) state <= IDLE;
      end
      if (wr_cmp_lo) begin
        cmp[31:0] <= wr_data;
        state     <= HALF;
      end
      if (wr_cmp_hi) begin
        cmp[63:32] <= wr_data;
        if (state == HALF) state <= en ? ARMED : IDLE;
      end
    end
  end
endmodule
